// File: rtl/tx_char_encoder_p.sv
// SpaceWire transmit character encoder: builds parity-correct bit sequences for
// each character, serializes them LSB-first and drives the Data/Strobe pair.
module tx_char_encoder_p (
   input  logic       posedge_clk,
   input  logic       rx_resetn,
   input  logic       tx_enable,
   input  logic       bit_en,
   input  logic       char_valid,
   input  logic [2:0] char_type,
   input  logic [7:0] char_data,
   output logic       char_ready,
   output logic       dout,
   output logic       sout,
   output logic       fct_sent
);

   localparam logic [2:0] CT_NULL     = 3'd0;
   localparam logic [2:0] CT_FCT      = 3'd1;
   localparam logic [2:0] CT_DATA     = 3'd2;
   localparam logic [2:0] CT_EOP      = 3'd3;
   localparam logic [2:0] CT_EEP      = 3'd4;
   localparam logic [2:0] CT_TIMECODE = 3'd5;

   logic [13:0] shift_reg;
   logic [3:0]  bit_cnt;
   logic        prev_xor;

   logic [2:0]  sel_type;
   logic [13:0] load_seq;
   logic [3:0]  load_len;
   logic        load_xor;
   logic        p_ctrl;
   logic        p_data;
   logic        load_slot;
   logic        next_bit;

   // Handshake: a character is transferred on a rising edge where char_valid and
   // char_ready are both high; char_ready only rises in the slot after a
   // character's final bit, and nothing is buffered.
   assign load_slot  = (bit_cnt == 4'd0);
   assign char_ready = tx_enable & bit_en & load_slot;

   // Odd parity: P = ~(flag ^ prev_xor), so a control flag gives prev_xor and a
   // data flag gives its complement. Inside ESC+X the ESC bits xor to zero.
   assign p_ctrl   = prev_xor;
   assign p_data   = ~prev_xor;
   assign sel_type = char_valid ? char_type : CT_NULL;

   // Sequences are stored with the first bit on the line at index 0.
   always_comb begin
      load_seq = 14'd0;
      load_len = 4'd8;
      load_xor = 1'b0;
      case (sel_type)
         CT_FCT: begin
            load_seq = {10'd0, 1'b0, 1'b0, 1'b1, p_ctrl};
            load_len = 4'd4;
            load_xor = 1'b0;
         end
         CT_DATA: begin
            load_seq = {4'd0, char_data, 1'b0, p_data};
            load_len = 4'd10;
            load_xor = ^char_data;
         end
         CT_EOP: begin
            load_seq = {10'd0, 1'b1, 1'b0, 1'b1, p_ctrl};
            load_len = 4'd4;
            load_xor = 1'b1;
         end
         CT_EEP: begin
            load_seq = {10'd0, 1'b0, 1'b1, 1'b1, p_ctrl};
            load_len = 4'd4;
            load_xor = 1'b1;
         end
         CT_TIMECODE: begin
            load_seq = {char_data, 1'b0, 1'b1, 3'b111, p_ctrl};
            load_len = 4'd14;
            load_xor = ^char_data;
         end
         default: begin
            load_seq = {6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, p_ctrl};
            load_len = 4'd8;
            load_xor = 1'b0;
         end
      endcase
   end

   assign next_bit = load_slot ? load_seq[0] : shift_reg[0];

   always_ff @(posedge posedge_clk or negedge rx_resetn) begin
      if (!rx_resetn) begin
         shift_reg <= 14'd0;
         bit_cnt   <= 4'd0;
         prev_xor  <= 1'b0;
         dout      <= 1'b0;
         sout      <= 1'b0;
         fct_sent  <= 1'b0;
      end else begin
         fct_sent <= 1'b0;
         if (!tx_enable) begin
            shift_reg <= 14'd0;
            bit_cnt   <= 4'd0;
            prev_xor  <= 1'b0;
            dout      <= 1'b0;
            sout      <= 1'b0;
         end else if (bit_en) begin
            dout <= next_bit;
            // Strobe toggles whenever data does not, so dout^sout flips every bit.
            sout <= sout ^ ~(next_bit ^ dout);
            if (load_slot) begin
               shift_reg <= load_seq >> 1;
               bit_cnt   <= load_len - 4'd1;
               prev_xor  <= load_xor;
               fct_sent  <= char_valid && (char_type == CT_FCT);
            end else begin
               shift_reg <= shift_reg >> 1;
               bit_cnt   <= bit_cnt - 4'd1;
            end
         end
      end
   end

endmodule

// File: doc/tx_char_encoder_p.md
# tx_char_encoder_p

SpaceWire character encoder and Data-Strobe serializer (ECSS-E-ST-50-12C) for the transmit side of the link. Accepts one character per handshake: data, EOP, EEP, FCT, NULL or time-code. Generates the odd parity bit across character boundaries, shifts bits out LSB-first and drives the D/S line pair. It fills idle time with NULLs automatically and feeds the receive path of the far-end node.

## Interface
- No parameters.
- posedge_clk  in  1  system clock; all state updates on the rising edge.
- rx_resetn  in  1  reset, asynchronous, active-low.
- tx_enable  in  1  link transmit enable from the link FSM; low holds the encoder cleared.
- bit_en  in  1  one-cycle tick per transmit bit period; the encoder advances one bit per tick.
- char_valid  in  1  a character is offered.
- char_type  in  3  0 NULL, 1 FCT, 2 DATA, 3 EOP, 4 EEP, 5 TIMECODE; 6 and 7 are treated as NULL.
- char_data  in  8  data byte (DATA) or time-code byte (TIMECODE); ignored otherwise.
- char_ready  out  1  combinational; equals tx_enable & bit_en & (bit_cnt==0).
- dout  out  1  registered SpaceWire Data line.
- sout  out  1  registered SpaceWire Strobe line.
- fct_sent  out  1  registered one-cycle pulse when an explicit FCT is loaded.

## Operation
- Character bit order, first on the line at left:
  - DATA: P,0,D0..D7 (10 bits).
  - FCT: P,1,0,0.
  - EOP: P,1,0,1.
  - EEP: P,1,1,0.
  - ESC: P,1,1,1.
  - NULL: ESC then FCT (8 bits).
  - TIMECODE: ESC then a data character carrying char_data (14 bits).
- Parity:
  - Each component's P = ~(flag ^ prev_xor).
  - prev_xor is the XOR of the data/control bits of the previously transmitted component: ESC 0, FCT 0, EOP 1, EEP 1, DATA ^byte.
  - For ESC+X sequences, X's parity uses the ESC bits, so prev_xor=0.
  - prev_xor updates at load, to the value of the last component loaded.
- State:
  - 14-bit shift register holding the loaded sequence; LSB goes out first.
  - bit_cnt (0..14): bits remaining.
  - prev_xor.
  - dout/sout.
- Load, on a posedge with tx_enable & bit_en & bit_cnt==0:
  - If char_valid, the offered character is accepted.
  - Otherwise a NULL is loaded.
  - The first bit (P) is driven to dout on the same edge.
  - bit_cnt becomes length-1.
- Shift, on tx_enable & bit_en & bit_cnt!=0: drive the next bit to dout, decrement bit_cnt.
- No bit_en: all state holds.
- D/S encoding: on every driven bit, sout_next = sout ^ ~(dout_next ^ dout). dout^sout therefore toggles once per bit.
- tx_enable low, checked before bit_en: on the next posedge clear dout, sout, bit_cnt, the shift register and prev_xor. The current character is abandoned mid-bit with no completion.
- fct_sent pulses only for char_type 1 accepted; it does not pulse for the FCT half of a NULL.

## Timing
- Reset values: dout=0, sout=0, fct_sent=0, char_ready=0. Internal: bit_cnt=0, prev_xor=0, shift register 0.
- Latency: the accepting edge puts P on dout. The last bit of a character is followed on the next bit_en by the first bit of the next character, with no gap.
- char_ready is high only in the final-bit-done slot. char_valid held across it gives back-to-back characters.
- Boundaries:
  - First character after enable uses prev_xor=0.
  - Asynchronous reset mid-character clears everything immediately.
  - bit_en asserted with tx_enable low has no effect.
  - char_valid with char_type 6/7 is accepted and transmitted as NULL.

## Test plan
- Reset, then tx_enable=1, bit_en every cycle, char_valid=0:
  - NULL bits 0,1,1,1,0,1,0,0.
  - dout 0,1,1,1,0,1,0,0; sout 1,1,0,1,1,1,1,0.
  - dout^sout alternates 1,0,1,0…
- After one NULL, DATA 0x5A then EOP:
  - Data bits 1,0,0,1,0,1,1,0,1,0.
  - EOP bits 0,1,0,1, with no idle bit between them.
  - char_ready high exactly once per character.
- After a NULL, TIMECODE 0x25: 14 bits 0,1,1,1,1,0,1,0,1,0,0,1,0,0.
- FCT after DATA 0x01:
  - P=~(1^1)=1; bits 1,1,0,0.
  - fct_sent pulses once at load.
  - A following NULL's ESC parity uses prev_xor=0.
- Mid-character disruption:
  - tx_enable dropped at bit 5 of a DATA char: next edge dout=sout=0, bit_cnt=0.
  - On re-enable, first bit is a NULL with P=0.
  - Repeat with rx_resetn pulsed mid-char; the same result is required.
- bit_en every 3rd cycle:
  - Outputs change only on tick edges.
  - char_ready is asserted only on tick cycles.
  - Sequence identical to the continuous-tick case.
